// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Purpose:
//   8-N-1 UART transmitter (8-E-1 when parity is compiled in). A byte is
//   accepted with a valid/ready handshake. It is then shifted out LSB first,
//   framed by one start bit (low) and one stop bit (high). Every bit is held
//   for CLKS_PER_BIT cycles of i_clk.
//
// Parameters:
//   CLK_HZ  - frequency of i_clk in Hz (PLL output), default 15938000
//   BAUD    - serial bit rate, default 115200
//
// Ports:
//   i_clk    in   1  sole clock, rising-edge logic
//   i_rst_n  in   1  asynchronous active-low reset
//   i_data   in   8  byte to transmit, sampled only on acceptance
//   i_valid  in   1  i_data holds a byte to send
//   o_ready  out  1  high only in IDLE; acceptance = i_valid && o_ready
//   o_tx     out  1  serial line, idle high, LSB first
//   o_busy   out  1  frame in progress (any state other than IDLE)
//
// Configuration:
//   UART_TX_PARITY_EN - when defined, an even-parity bit is inserted between
//                       the last data bit and the stop bit.
//                       The frame then lasts 11 bit times instead of 10.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_HZ = 15938000,
  parameter int BAUD   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  // Rounded-to-nearest divider so the bit period error stays within half a
  // clock.
  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

  // The baud counter only needs to hold CLKS_PER_BIT-1.
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  // A bit time of a single clock cannot be counted by the
  // load/decrement scheme below.
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_divider
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  // Explicit encodings make the unused codes well defined. The unused codes
  // are caught by the default branch of the state machine.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // The baud counter is reloaded at every bit boundary. A bit boundary is the
  // terminal count, so bit periods stay exact across the whole frame.
  wire bit_done = (baud_cnt == '0);

  // Single state machine with every output registered. o_tx therefore
  // changes exactly one clock after the decision that drives it.
  // Reset forces the line high through the flop's asynchronous set. This
  // aborts a frame without a low glitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_tx       <= 1'b1;
      o_ready    <= 1'b0;
      o_busy     <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        // o_ready is registered. It first rises on the edge after reset
        // release, and it stays high until a byte is taken.
        IDLE: begin
          o_tx    <= 1'b1;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
          if (i_valid && o_ready) begin
            shift_reg  <= i_data;
            bit_idx    <= '0;
            baud_cnt   <= BAUD_LOAD;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^i_data;
`endif
            o_tx       <= 1'b0;
            o_ready    <= 1'b0;
            o_busy     <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt <= BAUD_LOAD;
            o_tx     <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        // shift_reg[0] is the bit now on the line. shift_reg[1] is the bit
        // that goes out next.
        DATA: begin
          if (bit_done) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              o_tx  <= parity_bit;
              state <= PARITY;
`else
              o_tx  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift_reg <= shift_reg >> 1;
              o_tx      <= shift_reg[1];
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            baud_cnt <= BAUD_LOAD;
            o_tx     <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif

        // Going back to IDLE raises o_ready on the same edge that ends the
        // stop bit. The earliest next acceptance is therefore one cycle later.
        STOP: begin
          if (bit_done) begin
            o_tx    <= 1'b1;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        default: begin
          o_tx    <= 1'b1;
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
